// File: rtl/eforth1_pkg.sv
// Shared eForth1 definitions: inner-interpreter opcodes and data-stack micro-ops.
package eforth1_pkg;

  // Primitive opcodes seen by the inner interpreter's execution unit.
  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_LIT  = 5'd1,
    OP_DUP  = 5'd2,
    OP_DROP = 5'd3,
    OP_SWAP = 5'd4,
    OP_OVER = 5'd5,
    OP_ADD  = 5'd6,
    OP_SUB  = 5'd7,
    OP_AND  = 5'd8,
    OP_OR   = 5'd9,
    OP_XOR  = 5'd10,
    OP_EXIT = 5'd11
  } opcode_e;

  // Data-stack micro-ops; encodings 6 and 7 are unused and behave as NOP.
  // DUP is not an op: the caller issues SS_PUSH with din = tos.
  typedef enum logic [2:0] {
    SS_NOP  = 3'd0,
    SS_LOAD = 3'd1,
    SS_PUSH = 3'd2,
    SS_POP  = 3'd3,
    SS_POPL = 3'd4,
    SS_SWAP = 3'd5
  } ss_op_e;

endpackage

// File: rtl/eforth1_ss_ram.sv
// Spill array below S0: one synchronous write port, one asynchronous read port.
module eforth1_ss_ram #(
  parameter int DSZ   = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic [AW-1:0]  waddr_i,
  input  logic [DSZ-1:0] wdata_i,
  input  logic [AW-1:0]  raddr_i,
  output logic [DSZ-1:0] rdata_o
);

  logic [DSZ-1:0] mem [DEPTH-2];

  // Synchronous write of the spilled S0 value.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Asynchronous read; addresses past the array return 0 instead of garbage.
  assign rdata_o = (raddr_i < AW'(DEPTH - 2)) ? mem[raddr_i] : '0;

endmodule

// File: rtl/eforth1_dstack.sv
// eForth1 data-stack engine: cached TOS/S0 registers over a spill array,
// one micro-op per clock, sticky overflow/underflow flags.
// en qualifies op/din for exactly one cycle; there is no ready/busy, the
// engine accepts a new op every clock.
module eforth1_dstack
  import eforth1_pkg::*;
#(
  parameter int DSZ   = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  ss_op_e                   op,
  input  logic [DSZ-1:0]           din,
  input  logic                     clr,
  output logic [DSZ-1:0]           tos,
  output logic [DSZ-1:0]           s0,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     udf
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  logic [DSZ-1:0] tos_q, tos_d;
  logic [DSZ-1:0] s0_q, s0_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;
  logic           ovf_set, udf_set;

  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  rd_addr;
  logic [DSZ-1:0] rd_data;
  logic [DSZ-1:0] refill;
  logic           is_full;

  // Item directly below S0 sits at depth-3; the new S0 slot on a push is depth-2.
  assign rd_addr = depth_q[AW-1:0] - AW'(3);
  assign wr_addr = depth_q[AW-1:0] - AW'(2);
  assign is_full = (depth_q == DW'(DEPTH));
  // With fewer than three items there is nothing below S0, so S0 refills as 0.
  assign refill  = (depth_q >= DW'(3)) ? rd_data : '0;

  eforth1_ss_ram #(
    .DSZ   (DSZ),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (s0_q),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Decode the micro-op: legal ops update state, illegal ones only raise a flag.
  always_comb begin
    tos_d   = tos_q;
    s0_d    = s0_q;
    depth_d = depth_q;
    wr_en   = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (en) begin
      case (op)
        SS_LOAD: begin
          if (depth_q >= DW'(1)) tos_d = din;
          else                   udf_set = 1'b1;
        end
        SS_PUSH: begin
          if (!is_full) begin
            wr_en   = (depth_q >= DW'(2));
            s0_d    = tos_q;
            tos_d   = din;
            depth_d = depth_q + DW'(1);
          end else begin
            ovf_set = 1'b1;
          end
        end
        SS_POP: begin
          if (depth_q >= DW'(1)) begin
            tos_d   = s0_q;
            s0_d    = refill;
            depth_d = depth_q - DW'(1);
          end else begin
            udf_set = 1'b1;
          end
        end
        SS_POPL: begin
          if (depth_q >= DW'(2)) begin
            tos_d   = din;
            s0_d    = refill;
            depth_d = depth_q - DW'(1);
          end else begin
            udf_set = 1'b1;
          end
        end
        SS_SWAP: begin
          if (depth_q >= DW'(2)) begin
            tos_d = s0_q;
            s0_d  = tos_q;
          end else begin
            udf_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // A fresh error in the clearing cycle keeps the flag set.
    ovf_d = (ovf_q & ~clr) | ovf_set;
    udf_d = (udf_q & ~clr) | udf_set;
  end

  // State registers; reset discards whatever op is presented in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tos_q   <= '0;
      s0_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      s0_q    <= s0_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign tos   = tos_q;
  assign s0    = s0_q;
  assign depth = depth_q;
  assign empty = (depth_q == '0);
  assign full  = is_full;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_eforth1_dstack.sv
// Directed bench for eforth1_dstack with hand-computed expectations and a
// reference stack queue for the fill/drain pass.
module tb_eforth1_dstack;
  import eforth1_pkg::*;

  localparam int DSZ   = 32;
  localparam int DEPTH = 64;
  localparam int DW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  ss_op_e         op;
  logic [DSZ-1:0] din;
  logic           clr;
  logic [DSZ-1:0] tos;
  logic [DSZ-1:0] s0;
  logic [DW-1:0]  depth;
  logic           empty;
  logic           full;
  logic           ovf;
  logic           udf;

  always #5 clk = ~clk;

  eforth1_dstack #(.DSZ(DSZ), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .op    (op),
    .din   (din),
    .clr   (clr),
    .tos   (tos),
    .s0    (s0),
    .depth (depth),
    .empty (empty),
    .full  (full),
    .ovf   (ovf),
    .udf   (udf)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DSZ-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [DSZ-1:0] e_tos,
                             input logic [DSZ-1:0] e_s0, input int e_depth);
    check({tag, ".tos"}, 64'(tos), 64'(e_tos));
    check({tag, ".s0"}, 64'(s0), 64'(e_s0));
    check({tag, ".depth"}, 64'(depth), 64'(e_depth));
  endtask

  task automatic check_flags(input string tag, input logic e_empty, input logic e_full,
                             input logic e_ovf, input logic e_udf);
    check({tag, ".empty"}, 64'(empty), 64'(e_empty));
    check({tag, ".full"}, 64'(full), 64'(e_full));
    check({tag, ".ovf"}, 64'(ovf), 64'(e_ovf));
    check({tag, ".udf"}, 64'(udf), 64'(e_udf));
  endtask

  // ---------------- drivers ----------------
  // Inputs change #1 after the edge; outputs are sampled at the same point.
  task automatic drive(input logic e, input ss_op_e o, input logic [DSZ-1:0] d,
                       input logic c);
    en  = e;
    op  = o;
    din = d;
    clr = c;
    @(posedge clk);
    #1;
    en  = 1'b0;
    op  = SS_NOP;
    din = '0;
    clr = 1'b0;
  endtask

  task automatic do_op(input ss_op_e o, input logic [DSZ-1:0] d);
    drive(1'b1, o, d, 1'b0);
  endtask

  task automatic do_clr();
    drive(1'b0, SS_NOP, '0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    en  = 1'b0;
    op  = SS_NOP;
    din = '0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check_state("reset", 0, 0, 0);
    check_flags("reset", 1, 0, 0, 0);

    // push 1,2,3 then pop back to empty
    do_op(SS_PUSH, 1);
    do_op(SS_PUSH, 2);
    do_op(SS_PUSH, 3);
    check_state("push3", 3, 2, 3);
    do_op(SS_POP, 0);
    check_state("pop1", 2, 1, 2);
    do_op(SS_POP, 0);
    check_state("pop2", 1, 0, 1);
    do_op(SS_POP, 0);
    check_state("pop3", 0, 0, 0);
    check_flags("pop3", 1, 0, 0, 0);

    // POPL from [5,7], illegal SWAP at depth 1, then clear
    do_op(SS_PUSH, 5);
    do_op(SS_PUSH, 7);
    do_op(SS_POPL, 12);
    check_state("popl", 12, 0, 1);
    do_op(SS_SWAP, 0);
    check_state("swap_d1", 12, 0, 1);
    check("swap_d1.udf", 64'(udf), 64'(1));
    do_clr();
    check("clr.udf", 64'(udf), 64'(0));
    do_op(SS_POP, 0);
    check_state("drain1", 0, 0, 0);

    // fill to capacity, overflow, then drain against the reference queue
    for (int i = 0; i < DEPTH; i++) begin
      do_op(SS_PUSH, DSZ'(i));
      exp_q.push_back(DSZ'(i));
    end
    check_state("fill", DSZ'(DEPTH - 1), DSZ'(DEPTH - 2), DEPTH);
    check_flags("fill", 0, 1, 0, 0);
    do_op(SS_PUSH, 32'hDEAD);
    check_state("ovf_push", DSZ'(DEPTH - 1), DSZ'(DEPTH - 2), DEPTH);
    check_flags("ovf_push", 0, 1, 1, 0);
    for (int j = 0; j < DEPTH; j++) begin
      logic [DSZ-1:0] e_tos;
      logic [DSZ-1:0] e_s0;
      do_op(SS_POP, 0);
      void'(exp_q.pop_back());
      e_tos = (exp_q.size() > 0) ? exp_q[exp_q.size() - 1] : '0;
      e_s0  = (exp_q.size() > 1) ? exp_q[exp_q.size() - 2] : '0;
      check_state($sformatf("drain[%0d]", j), e_tos, e_s0, exp_q.size());
    end
    check_flags("drained", 1, 0, 1, 0);
    do_clr();
    check("clr.ovf", 64'(ovf), 64'(0));

    // back-to-back sequence, no idle cycles
    do_op(SS_PUSH, 32'hA);
    do_op(SS_PUSH, 32'hB);
    do_op(SS_SWAP, 0);
    check_state("b2b_swap", 32'hA, 32'hB, 2);
    do_op(SS_POPL, 32'h15);
    do_op(SS_LOAD, 32'h99);
    check_state("b2b", 32'h99, 0, 1);
    check_flags("b2b", 0, 0, 0, 0);

    // unknown op encoding behaves as NOP
    do_op(ss_op_e'(3'd7), 32'h1234);
    check_state("op7", 32'h99, 0, 1);
    check("op7.udf", 64'(udf), 64'(0));
    do_op(SS_POP, 0);

    // illegal LOAD on empty, then reset mid-PUSH at depth 4 clears everything
    do_op(SS_LOAD, 32'h42);
    check_state("load_empty", 0, 0, 0);
    check("load_empty.udf", 64'(udf), 64'(1));
    for (int i = 1; i <= 4; i++) do_op(SS_PUSH, DSZ'(i));
    check_state("pre_rst", 4, 3, 4);
    rst = 1'b1;
    do_op(SS_PUSH, 32'h55);
    rst = 1'b0;
    check_state("rst_mid", 0, 0, 0);
    check_flags("rst_mid", 1, 0, 0, 0);

    // en low ignores op/din for three cycles
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, SS_PUSH, 32'h77, 1'b0);
      check_state($sformatf("en0[%0d]", k), 0, 0, 0);
    end
    // clear and a new underflow in the same cycle: the error wins
    drive(1'b1, SS_POP, 0, 1'b1);
    check_state("clr_err", 0, 0, 0);
    check("clr_err.udf", 64'(udf), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eforth1_dstack.md
# eforth1_dstack

Data-stack engine for the eForth1 core: holds the cached top-of-stack (TOS) and next-on-stack (S0) registers plus a spill array, and executes one stack micro-op per clock on behalf of the inner interpreter. It sits directly under the inner interpreter's execution unit and serves the stack-side requests behind its PUSH/POP/ALU helpers. Overflow and underflow are detected in hardware and reported as sticky flags.

## Interface
- DSZ, 32, data width
- DEPTH, 64, total stack capacity in items, including TOS and S0; power of two, ≥4
- clk  in  1  clock, all state changes on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  op qualifier; when low the op is ignored
- op  in  ss_op_e (3)  stack micro-op
- din  in  DSZ  value loaded into TOS by LOAD/PUSH/POPL
- clr  in  1  clears ovf/udf
- tos  out  DSZ  top of stack, registered
- s0  out  DSZ  next on stack, registered
- depth  out  $clog2(DEPTH)+1  item count, 0..DEPTH
- empty  out  1  depth==0
- full  out  1  depth==DEPTH
- ovf  out  1  sticky overflow
- udf  out  1  sticky underflow

## Operation
- Storage: TOS reg, S0 reg, array mem[DEPTH-2]; item k below S0 lives at mem[depth-3-k].
- Ops, applied at posedge when en=1 and legal:
  - SS_NOP: hold.
  - SS_LOAD: tos<=din. Needs depth≥1.
  - SS_PUSH: mem[depth-2]<=s0 (only if depth≥2); s0<=tos; tos<=din; depth+1. Needs depth<DEPTH.
  - SS_POP: tos<=s0; s0<=mem[depth-3] (0 if depth<3); depth-1. Needs depth≥1.
  - SS_POPL: tos<=din; s0<=mem[depth-3] (0 if depth<3); depth-1. Needs depth≥2. This is the binary-ALU op; din is the caller's f(s0,tos).
  - SS_SWAP: tos<=s0; s0<=tos. Needs depth≥2.
  - SS_DUP is not an op; the caller issues PUSH with din=tos.
- Illegal op (precondition fails): no state change except ovf (PUSH when full) or udf (all others) set to 1.
- Sticky flags: clr=1 clears both; a new error in the same cycle as clr wins (flag stays 1).
- Array read is asynchronous (LUT RAM) at index depth-3, so the S0 refill needs no extra cycle. Array write is synchronous.
- The vacated S0 when depth drops to ≤1 reads as 0, never as stale data.
- Unknown op encodings are treated as NOP.

## Timing
- Reset: tos=0, s0=0, depth=0, empty=1, full=0, ovf=0, udf=0. Array contents are don't-care.
- rst has priority over en/op/clr; reset in the middle of any op sequence discards that cycle's op.
- Latency 1: the result of the op at edge N is visible on tos/s0/depth after edge N.
- Back-to-back ops every cycle, with no bubbles and no busy signal.
- en=0: op and din are ignored; clr still acts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- ss_op_e (SS_NOP=0, SS_LOAD, SS_PUSH, SS_POP, SS_POPL, SS_SWAP) goes in the shared eforth1 package/header, next to opcode_e, so the inner interpreter and this block share it.
- Sub-module eforth1_ss_ram: (DEPTH-2)×DSZ, one synchronous write port, one asynchronous read port. Everything else (pointer math, TOS/S0 regs, flags) stays in eforth1_dstack.

## Test plan
- Reset, then PUSH 1,2,3 → tos=3, s0=2, depth=3. Then POP ×3 → tos=0, depth=0, empty=1, udf=0.
- From the stack [5,7] (tos=7), POPL din=12 → tos=12, s0=0, depth=1. SWAP on depth 1 → state unchanged, udf=1. Then clr → udf=0.
- Fill to DEPTH with PUSH of values i, then PUSH 0xDEAD → full=1, ovf=1, tos=DEPTH-1 unchanged. Then POP DEPTH times → values return in order DEPTH-2..0, with the spill refill correct at every step.
- Back-to-back without idle cycles: PUSH 0xA, PUSH 0xB, SWAP, POPL din=0x15, LOAD din=0x99 → tos=0x99, depth=1, no flags.
- Assert rst while a PUSH is presented with depth=4 → next cycle depth=0, tos=0, s0=0, flags clear.
- en=0 with op=PUSH for 3 cycles → no change. Then clr and an illegal POP (depth=0) in the same cycle → udf=1.
